// File: rtl/cmod_s7_led_status.sv
// Status LED sequencer for the Cmod S7 receiver build.
// Turns receiver status into active-high LED drive requests for the board
// PWM dimmer: heartbeat, rx-active level, stretched detect flash, latched
// error flag, and an RGB state colour with blink.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   rx_active_i  receiver-enabled level (asynchronous to clk)
//   det_pulse_i  single-cycle signal-detect event
//   err_pulse_i  single-cycle error event
//   err_clr_i    clears the latched error
//   led_o        [0] heartbeat, [1] rx active, [2] detect flash, [3] error
//   rgb_r_o, rgb_g_o, rgb_b_o  RGB colour request
module cmod_s7_led_status #(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned HB_MS      = 500,
  parameter int unsigned STRETCH_MS = 100,
  parameter int unsigned BLINK_MS   = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_active_i,
  input  logic       det_pulse_i,
  input  logic       err_pulse_i,
  input  logic       err_clr_i,
  output logic [3:0] led_o,
  output logic       rgb_r_o,
  output logic       rgb_g_o,
  output logic       rgb_b_o
);

  localparam int unsigned TICK_DIV = CLK_FREQ / 1000;
  localparam int unsigned DIV_W    = $clog2(TICK_DIV);
  localparam int unsigned HB_W     = (HB_MS > 1) ? $clog2(HB_MS) : 1;
  localparam int unsigned STR_W    = $clog2(STRETCH_MS + 1);
  localparam int unsigned BLK_W    = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DETECT,
    ST_ERROR
  } state_t;

  // Registered state
  logic [DIV_W-1:0] div_cnt;
  logic [HB_W-1:0]  hb_cnt;
  logic             hb_led;
  logic             sync1;
  logic             sync2;
  logic             rx_q;
  logic [STR_W-1:0] stretch_cnt;
  logic             det_led;
  logic             err_q;
  state_t           state;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_ph;
  logic             rgb_r_q;
  logic             rgb_g_q;
  logic             rgb_b_q;

  // Next-state values
  logic [DIV_W-1:0] div_cnt_d;
  logic [HB_W-1:0]  hb_cnt_d;
  logic             hb_led_d;
  logic [STR_W-1:0] stretch_cnt_d;
  logic             det_led_d;
  logic             err_d;
  state_t           state_d;
  logic [BLK_W-1:0] blink_cnt_d;
  logic             blink_ph_d;
  logic             rgb_r_d;
  logic             rgb_g_d;
  logic             rgb_b_d;

  logic tick;

  // One-cycle strobe per millisecond
  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  // State register and all other registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      hb_cnt      <= '0;
      hb_led      <= 1'b0;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      rx_q        <= 1'b0;
      stretch_cnt <= '0;
      det_led     <= 1'b0;
      err_q       <= 1'b0;
      state       <= ST_IDLE;
      blink_cnt   <= '0;
      blink_ph    <= 1'b1;
      rgb_r_q     <= 1'b0;
      rgb_g_q     <= 1'b0;
      rgb_b_q     <= 1'b0;
    end else begin
      div_cnt     <= div_cnt_d;
      hb_cnt      <= hb_cnt_d;
      hb_led      <= hb_led_d;
      sync1       <= rx_active_i;
      sync2       <= sync1;
      rx_q        <= sync2;
      stretch_cnt <= stretch_cnt_d;
      det_led     <= det_led_d;
      err_q       <= err_d;
      state       <= state_d;
      blink_cnt   <= blink_cnt_d;
      blink_ph    <= blink_ph_d;
      rgb_r_q     <= rgb_r_d;
      rgb_g_q     <= rgb_g_d;
      rgb_b_q     <= rgb_b_d;
    end
  end

  // Next-state logic for counters, latch, FSM, blink and colour
  always_comb begin
    div_cnt_d     = div_cnt + DIV_W'(1);
    hb_cnt_d      = hb_cnt;
    hb_led_d      = hb_led;
    stretch_cnt_d = stretch_cnt;
    err_d         = err_q;
    state_d       = ST_IDLE;
    blink_cnt_d   = blink_cnt;
    blink_ph_d    = blink_ph;
    rgb_r_d       = 1'b0;
    rgb_g_d       = 1'b0;
    rgb_b_d       = 1'b0;

    if (tick) begin
      div_cnt_d = '0;
    end

    if (tick) begin
      if (hb_cnt == HB_W'(HB_MS - 1)) begin
        hb_cnt_d = '0;
        hb_led_d = ~hb_led;
      end else begin
        hb_cnt_d = hb_cnt + HB_W'(1);
      end
    end

    // A load takes precedence over a same-cycle tick decrement
    if (det_pulse_i) begin
      stretch_cnt_d = STR_W'(STRETCH_MS);
    end else if (tick && (stretch_cnt != '0)) begin
      stretch_cnt_d = stretch_cnt - STR_W'(1);
    end
    det_led_d = (stretch_cnt_d != '0);

    // Set beats clear
    if (err_pulse_i) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end

    // Priority selection, aligned with the stretch/error register updates
    if (err_d) begin
      state_d = ST_ERROR;
    end else if (stretch_cnt_d != '0) begin
      state_d = ST_DETECT;
    end else if (sync2) begin
      state_d = ST_ACTIVE;
    end

    // A new state restarts the blink lit
    if (state_d != state) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if (tick) begin
      if (blink_cnt == BLK_W'(BLINK_MS - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph;
      end else begin
        blink_cnt_d = blink_cnt + BLK_W'(1);
      end
    end

    case (state)
      ST_IDLE:   rgb_b_d = 1'b1;
      ST_ACTIVE: rgb_g_d = 1'b1;
      ST_DETECT: rgb_g_d = blink_ph;
      ST_ERROR:  rgb_r_d = blink_ph;
      default:   rgb_b_d = 1'b1;
    endcase
  end

  assign led_o   = {err_q, det_led, rx_q, hb_led};
  assign rgb_r_o = rgb_r_q;
  assign rgb_g_o = rgb_g_q;
  assign rgb_b_o = rgb_b_q;

endmodule

// File: tb/tb_cmod_s7_led_status.sv
// Self-checking bench for cmod_s7_led_status with CLK_FREQ=10_000
// (10 clocks per tick), HB_MS=4, STRETCH_MS=3, BLINK_MS=2.
// Time base: e = number of clk rising edges since reset release; outputs are
// sampled on the falling edge, inputs driven on the falling edge. Ticks take
// effect on edges where e % 10 == 0.
module tb_cmod_s7_led_status;

  localparam logic [6:0] M_ALL = 7'b1111111;
  localparam logic [6:0] M_ERR = 7'b1000000;
  localparam logic [6:0] M_DET = 7'b0100000;
  localparam logic [6:0] M_RX  = 7'b0010000;
  localparam logic [6:0] M_HB  = 7'b0001000;
  localparam logic [6:0] M_RGB = 7'b0000111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b0;
  logic       det = 1'b0;
  logic       err = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] led;
  logic       rgb_r;
  logic       rgb_g;
  logic       rgb_b;
  logic [6:0] obs;

  int e;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         at;
    logic [6:0] mask;
    logic [6:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];

  cmod_s7_led_status #(
    .CLK_FREQ  (10_000),
    .HB_MS     (4),
    .STRETCH_MS(3),
    .BLINK_MS  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_active_i(rx),
    .det_pulse_i(det),
    .err_pulse_i(err),
    .err_clr_i  (clr),
    .led_o      (led),
    .rgb_r_o    (rgb_r),
    .rgb_g_o    (rgb_g),
    .rgb_b_o    (rgb_b)
  );

  assign obs = {led, rgb_r, rgb_g, rgb_b};

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) e <= 0;
    else     e <= e + 1;
  end

  function automatic void expect_at(int at, logic [6:0] mask, logic [6:0] val, string tag);
    exp_t x;
    x.at   = at;
    x.mask = mask;
    x.val  = val & mask;
    x.tag  = tag;
    sb.push_back(x);
  endfunction

  function automatic int next_aligned(int from, int m);
    int d = from + 2;
    while (d % 10 != m) d++;
    return d;
  endfunction

  task automatic test_reset();
    exp_t ex;
    rst = 1'b1; rx = 1'b0; det = 1'b0; err = 1'b0; clr = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (obs !== 7'b0000000) begin
      n_errors++;
      $display("FAIL reset_hold got %b want %b", obs, 7'b0000000);
    end
    expect_at(1,   M_ALL, 7'b0000001, "first_cycle_idle");
    expect_at(9,   M_ALL, 7'b0000001, "before_first_tick");
    expect_at(39,  M_HB,  7'b0000000, "hb_before_tick4");
    expect_at(40,  M_ALL, 7'b0001001, "hb_toggle_tick4");
    expect_at(79,  M_HB,  7'b0001000, "hb_before_tick8");
    expect_at(80,  M_HB,  7'b0000000, "hb_toggle_tick8");
    expect_at(119, M_HB,  7'b0000000, "hb_before_tick12");
    expect_at(120, M_HB,  7'b0001000, "hb_toggle_tick12");
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== 7'b0000000) begin
      n_errors++;
      $display("FAIL release_e0 got %b want %b", obs, 7'b0000000);
    end
    while (e < 122) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at <= e) begin
        ex = sb.pop_front();
        n_checks++;
        if (ex.at != e || (obs & ex.mask) !== ex.val) begin
          n_errors++;
          $display("FAIL %s e=%0d due=%0d got %b want %b", ex.tag, e, ex.at, obs & ex.mask, ex.val);
        end
      end
    end
    while (sb.size() != 0) begin
      ex = sb.pop_front();
      n_errors++;
      $display("FAIL %s not reached (due %0d)", ex.tag, ex.at);
    end
  endtask

  task automatic test_rx_active();
    exp_t ex;
    int a = e + 2;
    int b = a + 20;
    expect_at(a + 2, M_RX | M_RGB, 7'b0000001, "rx_not_yet");
    expect_at(a + 3, M_RX | M_RGB, 7'b0010001, "rx_led_3_edges");
    expect_at(a + 4, M_RX | M_RGB, 7'b0010010, "rx_green_solid");
    expect_at(b + 2, M_RX | M_RGB, 7'b0010010, "rx_fall_not_yet");
    expect_at(b + 3, M_RX | M_RGB, 7'b0000010, "rx_led_fall");
    expect_at(b + 4, M_RX | M_RGB, 7'b0000001, "rx_back_blue");
    while (e < b + 6) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at <= e) begin
        ex = sb.pop_front();
        n_checks++;
        if (ex.at != e || (obs & ex.mask) !== ex.val) begin
          n_errors++;
          $display("FAIL %s e=%0d due=%0d got %b want %b", ex.tag, e, ex.at, obs & ex.mask, ex.val);
        end
      end
      rx = (e >= a && e < b);
    end
    rx = 1'b0;
    while (sb.size() != 0) begin
      ex = sb.pop_front();
      n_errors++;
      $display("FAIL %s not reached (due %0d)", ex.tag, ex.at);
    end
  endtask

  task automatic test_detect();
    exp_t ex;
    int d = next_aligned(e, 2);
    logic [6:0] m = M_DET | M_RGB;
    expect_at(d,      m, 7'b0000001, "det_before");
    expect_at(d + 1,  m, 7'b0100001, "det_led_rise");
    expect_at(d + 2,  m, 7'b0100010, "det_green_lit");
    expect_at(d + 8,  m, 7'b0100010, "det_blink_tick1");
    expect_at(d + 18, m, 7'b0100010, "det_blink_still_on");
    expect_at(d + 19, m, 7'b0100000, "det_blink_off");
    expect_at(d + 27, m, 7'b0100000, "det_led_before_tick3");
    expect_at(d + 28, m, 7'b0000000, "det_led_fall");
    expect_at(d + 29, m, 7'b0000001, "det_back_blue");
    while (e < d + 32) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at <= e) begin
        ex = sb.pop_front();
        n_checks++;
        if (ex.at != e || (obs & ex.mask) !== ex.val) begin
          n_errors++;
          $display("FAIL %s e=%0d due=%0d got %b want %b", ex.tag, e, ex.at, obs & ex.mask, ex.val);
        end
      end
      det = (e == d);
    end
    det = 1'b0;
    while (sb.size() != 0) begin
      ex = sb.pop_front();
      n_errors++;
      $display("FAIL %s not reached (due %0d)", ex.tag, ex.at);
    end
  endtask

  task automatic test_retrigger();
    exp_t ex;
    int d  = next_aligned(e, 2);
    int d2 = d + 20;
    int t  = d + 57;
    expect_at(d + 1,  M_DET, M_DET, "retrig_first_load");
    expect_at(d + 19, M_DET, M_DET, "retrig_before_second");
    expect_at(d + 21, M_DET, M_DET, "retrig_second_load");
    expect_at(d + 28, M_DET, M_DET, "retrig_extended");
    expect_at(d + 47, M_DET, M_DET, "retrig_before_end");
    expect_at(d + 48, M_DET, 7'b0, "retrig_fall");
    expect_at(t,      M_DET, 7'b0, "ontick_before");
    expect_at(t + 1,  M_DET, M_DET, "ontick_load");
    expect_at(t + 21, M_DET, M_DET, "ontick_not_decremented");
    expect_at(t + 30, M_DET, M_DET, "ontick_before_end");
    expect_at(t + 31, M_DET, 7'b0, "ontick_fall");
    while (e < t + 34) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at <= e) begin
        ex = sb.pop_front();
        n_checks++;
        if (ex.at != e || (obs & ex.mask) !== ex.val) begin
          n_errors++;
          $display("FAIL %s e=%0d due=%0d got %b want %b", ex.tag, e, ex.at, obs & ex.mask, ex.val);
        end
      end
      det = (e == d || e == d2 || e == t);
    end
    det = 1'b0;
    while (sb.size() != 0) begin
      ex = sb.pop_front();
      n_errors++;
      $display("FAIL %s not reached (due %0d)", ex.tag, ex.at);
    end
  endtask

  task automatic test_error();
    exp_t ex;
    int d = next_aligned(e, 2);
    logic [6:0] m = M_ERR | M_RGB;
    expect_at(d + 5,   m, 7'b0000010, "err_before");
    expect_at(d + 6,   M_ERR | M_DET | M_RGB, 7'b1100010, "err_latch_rise");
    expect_at(d + 7,   m, 7'b1000100, "err_red_lit");
    expect_at(d + 18,  m, 7'b1000100, "err_red_still_on");
    expect_at(d + 19,  m, 7'b1000000, "err_red_off");
    expect_at(d + 38,  m, 7'b1000000, "err_red_still_off");
    expect_at(d + 39,  m, 7'b1000100, "err_red_on_again");
    expect_at(d + 43,  M_RX, M_RX, "err_rx_up");
    expect_at(d + 58,  m, 7'b1000100, "err_red_on_last");
    expect_at(d + 59,  m, 7'b1000000, "err_red_off_again");
    expect_at(d + 60,  m, 7'b1000000, "clr_before");
    expect_at(d + 61,  m, 7'b0000000, "clr_latch_fall");
    expect_at(d + 62,  m, 7'b0000010, "clr_to_active");
    expect_at(d + 71,  m, 7'b1000010, "set_beats_clr");
    expect_at(d + 72,  m, 7'b1000100, "set_clr_red_lit");
    expect_at(d + 86,  M_ERR | M_DET | M_RGB, 7'b0100100, "clr_while_det");
    expect_at(d + 87,  m, 7'b0000010, "clr_to_detect");
    expect_at(d + 99,  m, 7'b0000000, "detect_blink_off");
    expect_at(d + 109, M_ERR | M_DET | M_RX | M_RGB, 7'b0000001, "err_seq_idle");
    while (e < d + 112) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at <= e) begin
        ex = sb.pop_front();
        n_checks++;
        if (ex.at != e || (obs & ex.mask) !== ex.val) begin
          n_errors++;
          $display("FAIL %s e=%0d due=%0d got %b want %b", ex.tag, e, ex.at, obs & ex.mask, ex.val);
        end
      end
      det = (e == d || e == d + 80);
      err = (e == d + 5 || e == d + 70);
      clr = (e == d + 60 || e == d + 70 || e == d + 85);
      rx  = (e >= d + 40 && e < d + 100);
    end
    det = 1'b0; err = 1'b0; clr = 1'b0; rx = 1'b0;
    while (sb.size() != 0) begin
      ex = sb.pop_front();
      n_errors++;
      $display("FAIL %s not reached (due %0d)", ex.tag, ex.at);
    end
  endtask

  task automatic test_reset_mid();
    exp_t ex;
    int d = next_aligned(e, 2);
    expect_at(d + 1,  M_ERR | M_DET | M_RGB, 7'b1100001, "mid_set");
    expect_at(d + 2,  M_ERR | M_DET | M_RGB, 7'b1100100, "mid_red");
    expect_at(d + 12, M_ERR | M_DET, 7'b1100000, "mid_before_rst");
    while (e < d + 12) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at <= e) begin
        ex = sb.pop_front();
        n_checks++;
        if (ex.at != e || (obs & ex.mask) !== ex.val) begin
          n_errors++;
          $display("FAIL %s e=%0d due=%0d got %b want %b", ex.tag, e, ex.at, obs & ex.mask, ex.val);
        end
      end
      det = (e == d);
      err = (e == d);
    end
    det = 1'b0; err = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 7'b0000000) begin
      n_errors++;
      $display("FAIL mid_async_reset got %b want %b", obs, 7'b0000000);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== 7'b0000000) begin
      n_errors++;
      $display("FAIL mid_reset_hold got %b want %b", obs, 7'b0000000);
    end
    expect_at(1,  M_ALL, 7'b0000001, "mid_release_blue");
    expect_at(2,  M_ALL, 7'b0000001, "mid_release_stable");
    expect_at(35, M_ALL, 7'b0000001, "mid_no_stale_stretch");
    rst = 1'b0;
    while (e < 36) begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at <= e) begin
        ex = sb.pop_front();
        n_checks++;
        if (ex.at != e || (obs & ex.mask) !== ex.val) begin
          n_errors++;
          $display("FAIL %s e=%0d due=%0d got %b want %b", ex.tag, e, ex.at, obs & ex.mask, ex.val);
        end
      end
    end
    while (sb.size() != 0) begin
      ex = sb.pop_front();
      n_errors++;
      $display("FAIL %s not reached (due %0d)", ex.tag, ex.at);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at e=%0d", e);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rx_active();
    test_detect();
    test_retrigger();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
